// File: rtl/flag_branch_unit.sv
// flag_branch_unit: architectural V/N/Z flag register with same-cycle forwarding,
// conditional branch resolution, a registered one-cycle PC redirect with a
// shadow state, and saturating branch statistics.
module flag_branch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_v,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        ex_valid,
    input  logic [2:0]  flag_wr,
    input  logic        br_valid,
    input  logic [2:0]  br_cond,
    input  logic [15:0] br_target,
    input  logic        stall,
    input  logic        flush,
    input  logic        cnt_clr,
    output logic        flag_v,
    output logic        flag_n,
    output logic        flag_z,
    output logic        redirect,
    output logic [15:0] redirect_pc,
    output logic [15:0] br_count,
    output logic [15:0] taken_count
);

    typedef enum logic {RUN = 1'b0, REDIR = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        flag_v_q, flag_n_q, flag_z_q;
    logic        flag_v_d, flag_n_d, flag_z_d;
    logic [15:0] redirect_pc_q, redirect_pc_d;
    logic [15:0] br_count_q, br_count_d;
    logic [15:0] taken_count_q, taken_count_d;

    logic fw, ev, cond_true, taken;
    logic eff_v, eff_n, eff_z;

    // Forwarded flags and branch resolution; the next flag state is the forwarded value.
    always_comb begin
        fw    = ex_valid & ~stall & ~flush;
        eff_v = (fw & flag_wr[2]) ? alu_v : flag_v_q;
        eff_n = (fw & flag_wr[1]) ? alu_n : flag_n_q;
        eff_z = (fw & flag_wr[0]) ? alu_z : flag_z_q;
        case (br_cond)
            3'b000:  cond_true = ~eff_z;
            3'b001:  cond_true = eff_z;
            3'b010:  cond_true = ~eff_z & ~eff_n;
            3'b011:  cond_true = eff_n;
            3'b100:  cond_true = ~eff_n;
            3'b101:  cond_true = eff_n | eff_z;
            3'b110:  cond_true = eff_v;
            default: cond_true = 1'b1;
        endcase
        // Branches arriving in the REDIR (shadow) cycle are being squashed by fetch.
        ev    = br_valid & ~stall & ~flush & (state_q == RUN);
        taken = ev & cond_true;
        flag_v_d = eff_v;
        flag_n_d = eff_n;
        flag_z_d = eff_z;
    end

    // Redirect FSM next state: one REDIR cycle per taken branch, stretched by stall.
    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        if (!stall) begin
            case (state_q)
                RUN: begin
                    if (taken) begin
                        state_d       = REDIR;
                        redirect_pc_d = br_target;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Saturating statistics; clear wins over a same-cycle increment and ignores stall.
    always_comb begin
        br_count_d    = br_count_q;
        taken_count_d = taken_count_q;
        if (ev && br_count_q != 16'hFFFF)
            br_count_d = br_count_q + 16'd1;
        if (taken && taken_count_q != 16'hFFFF)
            taken_count_d = taken_count_q + 16'd1;
        if (cnt_clr) begin
            br_count_d    = 16'd0;
            taken_count_d = 16'd0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            flag_v_q      <= 1'b0;
            flag_n_q      <= 1'b0;
            flag_z_q      <= 1'b0;
            redirect_pc_q <= 16'd0;
            br_count_q    <= 16'd0;
            taken_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            flag_v_q      <= flag_v_d;
            flag_n_q      <= flag_n_d;
            flag_z_q      <= flag_z_d;
            redirect_pc_q <= redirect_pc_d;
            br_count_q    <= br_count_d;
            taken_count_q <= taken_count_d;
        end
    end

    assign flag_v      = flag_v_q;
    assign flag_n      = flag_n_q;
    assign flag_z      = flag_z_q;
    assign redirect    = (state_q == REDIR);
    assign redirect_pc = redirect_pc_q;
    assign br_count    = br_count_q;
    assign taken_count = taken_count_q;

endmodule
